// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB arbiter bundle: FU requests, grants, broadcast and writeback ports
interface cdb_arbiter_if #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 3,
    parameter int NUM_FU    = 4
);
    logic [NUM_FU-1:0]           req;
    logic [NUM_FU*REG_INDEX-1:0] req_dest;
    logic [NUM_FU*WORD_SIZE-1:0] req_data;
    logic [NUM_FU-1:0]           gnt;

    logic                        cdb_valid;
    logic [FU_INDEX-1:0]         cdb_tag;
    logic [REG_INDEX-1:0]        cdb_dest;
    logic [WORD_SIZE-1:0]        cdb_data;

    logic [REG_INDEX-1:0]        status_query_reg;
    logic [FU_INDEX-1:0]         status_query;

    logic [REG_INDEX-1:0]        write_reg_src;
    logic [WORD_SIZE-1:0]        write_reg_data;
    logic                        write_reg_enable;
    logic [REG_INDEX-1:0]        write_rs_src;
    logic [FU_INDEX-1:0]         write_rs_status;
    logic                        write_rs_enable;

    modport master (
        input  req, req_dest, req_data, status_query,
        output gnt, cdb_valid, cdb_tag, cdb_dest, cdb_data, status_query_reg,
               write_reg_src, write_reg_data, write_reg_enable,
               write_rs_src, write_rs_status, write_rs_enable
    );

    modport slave (
        output req, req_dest, req_data, status_query,
        input  gnt, cdb_valid, cdb_tag, cdb_dest, cdb_data, status_query_reg,
               write_reg_src, write_reg_data, write_reg_enable,
               write_rs_src, write_rs_status, write_rs_enable
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with tag-checked writeback; optional CDB_STARVE_CNT_EN wait counters
module cdb_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 3,
    parameter int NUM_FU    = 4,
    parameter int READY     = 0
) (
    input  logic                clk,
    input  logic                reset,
    cdb_arbiter_if.master       bus
`ifdef CDB_STARVE_CNT_EN
    ,
    output logic [NUM_FU-1:0]   starve_flag
`endif
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]     last_q;
    logic [PTR_W:0]       cand;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic [NUM_FU-1:0]    gnt_vec;

    logic                 cdb_valid_q;
    logic [FU_INDEX-1:0]  cdb_tag_q;
    logic [REG_INDEX-1:0] cdb_dest_q;
    logic [WORD_SIZE-1:0] cdb_data_q;
    logic                 hit;

    logic [REG_INDEX-1:0] dest_arr [NUM_FU];
    logic [WORD_SIZE-1:0] data_arr [NUM_FU];

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign dest_arr[g] = bus.req_dest[g*REG_INDEX +: REG_INDEX];
        assign data_arr[g] = bus.req_data[g*WORD_SIZE +: WORD_SIZE];
    end

    // Search starts one past the last winner and wraps, so the previous winner ranks lowest.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_FU; k++) begin
            cand = {1'b0, last_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_FU)) begin
                cand = cand - (PTR_W+1)'(NUM_FU);
            end
            if (!gnt_any && bus.req[cand[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
        if (reset) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= FU_INDEX'(READY);
            cdb_dest_q  <= '0;
            cdb_data_q  <= '0;
            last_q      <= PTR_W'(NUM_FU - 1);
        end else if (gnt_any) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= FU_INDEX'(gnt_idx) + FU_INDEX'(1);
            cdb_dest_q  <= dest_arr[gnt_idx];
            cdb_data_q  <= data_arr[gnt_idx];
            last_q      <= gnt_idx;
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    // A result whose register was renamed since issue still broadcasts but must not retire.
    assign hit = cdb_valid_q && !reset && (bus.status_query == cdb_tag_q);

    assign bus.gnt              = gnt_vec;
    assign bus.cdb_valid        = cdb_valid_q;
    assign bus.cdb_tag          = cdb_tag_q;
    assign bus.cdb_dest         = cdb_dest_q;
    assign bus.cdb_data         = cdb_data_q;
    assign bus.status_query_reg = cdb_dest_q;
    assign bus.write_reg_src    = cdb_dest_q;
    assign bus.write_reg_data   = cdb_data_q;
    assign bus.write_reg_enable = hit;
    assign bus.write_rs_src     = cdb_dest_q;
    assign bus.write_rs_status  = FU_INDEX'(READY);
    assign bus.write_rs_enable  = hit;

`ifdef CDB_STARVE_CNT_EN
    logic [3:0] wait_cnt [NUM_FU];

    // A healthy round-robin never lets a counter reach NUM_FU; the flag marks a fairness bug.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset) begin
                wait_cnt[i]    <= '0;
                starve_flag[i] <= 1'b0;
            end else begin
                if (!bus.req[i] || gnt_vec[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != 4'hf) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
                starve_flag[i] <= (int'(wait_cnt[i]) >= NUM_FU);
`ifndef SYNTHESIS
                if (!starve_flag[i] && (int'(wait_cnt[i]) >= NUM_FU)) begin
                    $display("%0t cdb_arbiter: starve_flag rise on FU %0d", $realtime, i);
                end
`endif
            end
        end
    end
`endif
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus arbiter/scheduler for the Tomasulo back end.
- Each cycle it picks one of NUM_FU functional units with a finished result, round-robin, and registers that result onto the CDB.
- During the broadcast cycle it checks the destination register's current rename tag in the register-status table. The register file is written, and the status returned to READY, only if the broadcasting FU still owns the register.

Parameters:
- WORD_SIZE, 32, data width
- REG_INDEX, 5, register index width
- FU_INDEX, 3, FU tag width; tag 0 = READY (no producer)
- NUM_FU, 4, number of requesters; requester i carries tag i+1; requires NUM_FU+1 <= 2^FU_INDEX
- READY, 0, status value meaning "no pending producer"

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_FU  result-ready request per FU
- req_dest  in  NUM_FU*REG_INDEX  packed destination reg; slice i belongs to FU i
- req_data  in  NUM_FU*WORD_SIZE  packed result data
- gnt  out  NUM_FU  one-hot grant, combinational, same cycle as req
- cdb_valid  out  1  registered broadcast valid
- cdb_tag  out  FU_INDEX  registered tag of broadcasting FU
- cdb_dest  out  REG_INDEX  registered destination reg
- cdb_data  out  WORD_SIZE  registered result
- status_query_reg  out  REG_INDEX  = cdb_dest, to a status read port
- status_query  in  FU_INDEX  current status of status_query_reg
- write_reg_src  out  REG_INDEX  register-file write address (= cdb_dest)
- write_reg_data  out  WORD_SIZE  register-file write data (= cdb_data)
- write_reg_enable  out  1  register-file write enable
- write_rs_src  out  REG_INDEX  status write address (= cdb_dest)
- write_rs_status  out  FU_INDEX  always READY
- write_rs_enable  out  1  status clear enable

Behaviour:
- Reset (synchronous):
  - cdb_valid=0; cdb_tag=READY; cdb_dest=0; cdb_data=0.
  - Round-robin pointer last=NUM_FU-1, so FU0 has top priority after reset.
  - gnt=0 while reset=1.
- Arbitration (combinational):
  - Search req from index last+1 upward, wrapping modulo NUM_FU; first set bit wins.
  - gnt is one-hot, or 0 when req==0.
- Handshake:
  - An FU holds req, req_dest and req_data stable until it sees gnt[i]=1 in a cycle. That grant consumes the request.
  - The FU drops req or presents a new result the next cycle.
- Registered broadcast, 1-cycle latency:
  - At the rising edge with a grant to i: cdb_valid<=1, cdb_tag<=i+1, cdb_dest<=req_dest[i], cdb_data<=req_data[i], last<=i.
  - With no grant: cdb_valid<=0; last and the other cdb fields hold.
- Writeback (combinational from the registered CDB):
  - hit = cdb_valid && (status_query == cdb_tag).
  - write_reg_enable = hit; write_rs_enable = hit.
  - A stale result (register renamed to another FU since issue) is still broadcast on the CDB for reservation stations, but is not written to the register file.
- Conflict with issue: write_rs connects to status port 1 and issue to port 2. When both target the same register in the same cycle, the new rename wins.
- Throughput and fairness:
  - One broadcast per cycle, back to back.
  - With all NUM_FU requesting continuously, grant order is 0,1,..,NUM_FU-1,0,...
  - A requester waits at most NUM_FU-1 cycles.
- Reset mid-operation: pending grants are discarded and no writeback fires in the reset cycle. FUs re-request after reset.
- Destination register 0 is not special-cased here.

Optional Feature:
- Macro: CDB_STARVE_CNT_EN.
- Defined:
  - Adds output starve_flag [NUM_FU], registered, and a per-FU 4-bit saturating wait counter.
  - The counter increments each cycle req[i]=1 && gnt[i]=0, clears on grant or when req[i]=0, and resets to 0.
  - starve_flag[i]=1 when counter[i] >= NUM_FU, which is an arbitration-bug detector.
  - A $display prints $realtime and the FU index on each flag rise.
- Undefined: no counters, no port, no display.

Test Plan:
- Reset, then req=4'b0000 for 3 cycles -> gnt=0, cdb_valid=0, write_reg_enable=0.
- req=4'b1111 held 8 cycles, each granted FU presenting a new result -> gnt sequence 0001,0010,0100,1000,0001,...; cdb_tag 1,2,3,4,1,... one cycle later.
- FU2 alone requests dest=11, data=0xDEADBEEF, status_query=3 -> next cycle cdb_valid=1, cdb_tag=3, write_reg_enable=1, write_reg_src=11, write_rs_enable=1, write_rs_status=0.
- Same as above but status_query=1 (renamed) -> cdb_valid=1, write_reg_enable=0, write_rs_enable=0.
- After FU1 is granted, req=4'b0011 -> FU0 granted next, not FU1; then FU1.
- Assert reset while req=4'b1111 -> the following cycle cdb_valid=0 and the first grant after reset is FU0. With CDB_STARVE_CNT_EN, starve_flag never rises in the round-robin test.
